// File: rtl/ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe_stage
// Description : Elastic EX->MEM stage with optional skid entry, flush, store
//               lane alignment/byte enables and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe_stage #(
    parameter int XLEN   = 32,
    parameter int RD_W   = 5,
    parameter int RSRC_W = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                valid_e,
    output logic                ready_e,
    input  logic [XLEN-1:0]     AluoutE,
    input  logic [RD_W-1:0]     rdE,
    input  logic [XLEN-1:0]     Mem_dataE,
    input  logic [2:0]          funct3E,
    input  logic                RegWriteE,
    input  logic [RSRC_W-1:0]   ResultSrcE,
    input  logic                MemWriteE,
    output logic                valid_m,
    input  logic                ready_m,
    output logic [XLEN-1:0]     AluoutM,
    output logic [RD_W-1:0]     rdM,
    output logic [XLEN-1:0]     Mem_dataM,
    output logic [XLEN/8-1:0]   byte_enM,
    output logic                misalignM,
    output logic [2:0]          funct3M,
    output logic                RegWriteM,
    output logic [RSRC_W-1:0]   ResultSrcM,
    output logic                MemWriteM,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef struct packed {
        logic [XLEN-1:0]   alu;
        logic [RD_W-1:0]   rd;
        logic [XLEN-1:0]   data;
        logic [BE_W-1:0]   be;
        logic              mis;
        logic [2:0]        f3;
        logic              regw;
        logic [RSRC_W-1:0] rsrc;
        logic              memw;
    } entry_t;

    entry_t           in_entry;
    entry_t           main_q;
    logic             main_valid;
    logic [OFF_W-1:0] off;
    logic [BE_W-1:0]  be_one;
    logic [BE_W-1:0]  be_two;
    logic [BE_W-1:0]  be_four;
    logic             accept;
    logic             drain;

    assign accept = valid_e & ready_e & ~flush;
    assign drain  = main_valid & ready_m;

    // Lane replication and byte enables are resolved here so MEM sees them registered.
    always_comb begin
        off        = AluoutE[OFF_W-1:0];
        be_one     = '0;
        be_one[0]  = 1'b1;
        be_two     = '0;
        be_two[1:0]  = 2'b11;
        be_four    = '0;
        be_four[3:0] = 4'hF;

        in_entry      = '0;
        in_entry.alu  = AluoutE;
        in_entry.rd   = rdE;
        in_entry.f3   = funct3E;
        in_entry.regw = RegWriteE;
        in_entry.rsrc = ResultSrcE;
        in_entry.memw = MemWriteE;

        case (funct3E[1:0])
            2'b00: begin
                in_entry.data = {BE_W{Mem_dataE[7:0]}};
                in_entry.be   = be_one << off;
                in_entry.mis  = 1'b0;
            end
            2'b01: begin
                in_entry.data = {(XLEN/16){Mem_dataE[15:0]}};
                in_entry.be   = be_two << off;
                in_entry.mis  = off[0];
            end
            2'b10: begin
                in_entry.data = {(XLEN/32){Mem_dataE[31:0]}};
                in_entry.be   = be_four << off;
                in_entry.mis  = |off[1:0];
            end
            default: begin
                in_entry.data = Mem_dataE;
                in_entry.be   = '1;
                in_entry.mis  = (XLEN == 64) ? (|off) : 1'b1;
            end
        endcase

        if (in_entry.mis) begin
            in_entry.be = '0;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            entry_t skid_q;
            logic   skid_valid;

            assign ready_e = ~skid_valid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_q     <= '0;
                    main_valid <= 1'b0;
                    skid_q     <= '0;
                    skid_valid <= 1'b0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (skid_valid) begin
                    // ready_e is low here, so no new entry can arrive.
                    if (drain) begin
                        main_q     <= skid_q;
                        skid_valid <= 1'b0;
                    end
                end else if (accept) begin
                    if (!main_valid || drain) begin
                        main_q     <= in_entry;
                        main_valid <= 1'b1;
                    end else begin
                        skid_q     <= in_entry;
                        skid_valid <= 1'b1;
                    end
                end else if (drain) begin
                    main_valid <= 1'b0;
                end
            end
        end else begin : g_noskid
            assign ready_e = ~main_valid | ready_m;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_q     <= '0;
                    main_valid <= 1'b0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (accept) begin
                    main_q     <= in_entry;
                    main_valid <= 1'b1;
                end else if (drain) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !ready_m && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign valid_m    = main_valid;
    assign AluoutM    = main_q.alu;
    assign rdM        = main_q.rd;
    assign Mem_dataM  = main_q.data;
    assign byte_enM   = main_q.be;
    assign misalignM  = main_q.mis;
    assign funct3M    = main_q.f3;
    assign ResultSrcM = main_q.rsrc;
    assign RegWriteM  = main_q.regw & main_valid;
    assign MemWriteM  = main_q.memw & main_valid & ~main_q.mis;

endmodule
`default_nettype wire
